// File: rtl/mult_seq.sv
// Iterative shift-add RV32M/RV64M multiplier (MUL/MULH/MULHSU/MULHU), RADIX_BITS multiplier bits per cycle.
// Optional feature: MULT_ZERO_BYPASS_EN shortcuts zero operands straight to the finalize cycle.
module mult_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            mul_op,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int N  = DATA_WIDTH / RADIX_BITS;
  localparam int CW = $clog2(N + 1);
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [CW-1:0] LAST = CW'(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_r, state_s;
  logic [1:0]              op_r;
  logic                    sign_r;
  logic [PW-1:0]           mcand_r;
  logic [DATA_WIDTH-1:0]   mplier_r;
  logic [CW-1:0]           count_r;
  logic [PW-1:0]           acc_r;
  logic [DATA_WIDTH-1:0]   result_r;

  logic                    accept_s;
  logic                    last_s;
  logic                    bypass_s;
  logic                    a_neg_s, b_neg_s;
  logic [DATA_WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [PW-1:0]           acc_add_s;
  logic [PW-1:0]           prod_s;
  logic [DATA_WIDTH-1:0]   result_s;

  // Request decode: operand signs, magnitudes and acceptance.
  always_comb begin
    accept_s = in_valid && (state_r == IDLE) && !flush;
    last_s   = (count_r == LAST);
    a_neg_s  = data_a[DATA_WIDTH-1] && ((mul_op == 2'b01) || (mul_op == 2'b10));
    b_neg_s  = data_b[DATA_WIDTH-1] && (mul_op == 2'b01);
    if (a_neg_s) begin
      a_mag_s = (~data_a) + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      a_mag_s = data_a;
    end
    if (b_neg_s) begin
      b_mag_s = (~data_b) + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      b_mag_s = data_b;
    end
`ifdef MULT_ZERO_BYPASS_EN
    bypass_s = (data_a == {DATA_WIDTH{1'b0}}) || (data_b == {DATA_WIDTH{1'b0}});
`else
    bypass_s = 1'b0;
`endif
  end

  // One radix step of partial products plus the signed, half-selected final value.
  always_comb begin
    acc_add_s = acc_r;
    for (int i = 0; i < RADIX_BITS; i++) begin
      if (mplier_r[i]) begin
        acc_add_s = acc_add_s + (mcand_r << i);
      end else begin
        acc_add_s = acc_add_s;
      end
    end
    if (sign_r) begin
      prod_s = (~acc_r) + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      prod_s = acc_r;
    end
    if (op_r == 2'b00) begin
      result_s = prod_s[DATA_WIDTH-1:0];
    end else begin
      result_s = prod_s[PW-1:DATA_WIDTH];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; flush wins over everything.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
    if (flush) begin
      state_s = IDLE;
    end else begin
      state_s = state_s;
    end
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath: latch operands, iterate, then register the selected half one cycle after the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r     <= 2'b00;
      sign_r   <= 1'b0;
      mcand_r  <= {PW{1'b0}};
      mplier_r <= {DATA_WIDTH{1'b0}};
      count_r  <= {CW{1'b0}};
      acc_r    <= {PW{1'b0}};
      result_r <= {DATA_WIDTH{1'b0}};
    end else if (flush) begin
      result_r <= result_r;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r     <= mul_op;
            sign_r   <= a_neg_s ^ b_neg_s;
            mcand_r  <= {{DATA_WIDTH{1'b0}}, a_mag_s};
            acc_r    <= {PW{1'b0}};
            if (bypass_s) begin
              mplier_r <= {DATA_WIDTH{1'b0}};
              count_r  <= LAST;
            end else begin
              mplier_r <= b_mag_s;
              count_r  <= {CW{1'b0}};
            end
          end else begin
            count_r <= count_r;
          end
        end
        BUSY: begin
          if (last_s) begin
            result_r <= result_s;
          end else begin
            acc_r    <= acc_add_s;
            mplier_r <= mplier_r >> RADIX_BITS;
            mcand_r  <= mcand_r << RADIX_BITS;
            count_r  <= count_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

  assign result = result_r;

endmodule

// File: tb/tb_mult_seq.sv
// Directed self-checking bench for mult_seq: radix-1 and radix-4 instances side by side.
module tb_mult_seq;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid0, in_valid1;
  logic        in_ready0, in_ready1;
  logic [1:0]  mul_op;
  logic [31:0] data_a, data_b;
  logic        out_valid0, out_valid1;
  logic        out_ready;
  logic [31:0] result0, result1;

  int checks;
  int errors;

  mult_seq #(.DATA_WIDTH(32), .RADIX_BITS(1)) dut_r1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid0), .in_ready(in_ready0),
    .mul_op(mul_op), .data_a(data_a), .data_b(data_b),
    .out_valid(out_valid0), .out_ready(out_ready), .result(result0)
  );

  mult_seq #(.DATA_WIDTH(32), .RADIX_BITS(4)) dut_r4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .mul_op(mul_op), .data_a(data_a), .data_b(data_b),
    .out_valid(out_valid1), .out_ready(out_ready), .result(result1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge and wait for out_valid; lat counts edges after the accepting edge.
  task automatic do_mul(input int sel, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    int w;
    w = 0;
    while (!((sel != 0) ? in_ready1 : in_ready0) && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) check("ready_timeout", 64'd0, 64'd1);
    mul_op = op;
    data_a = a;
    data_b = b;
    if (sel != 0) in_valid1 = 1'b1;
    else in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    lat = 0;
    while (!((sel != 0) ? out_valid1 : out_valid0) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 200) check("valid_timeout", 64'd0, 64'd1);
    res = (sel != 0) ? result1 : result0;
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [31:0] res;
  logic [31:0] held;
  int          lat;
  int          seen;

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    out_ready = 1'b0;
    mul_op    = 2'b00;
    data_a    = 32'd0;
    data_b    = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready0}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid0}, 64'd0);
    check("rst_result", {32'd0, result0}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MUL low half with latency and then a 5-cycle consumer stall.
    do_mul(0, 2'b00, 32'd7, 32'd6, res, lat);
    check("mul_7x6", {32'd0, res}, 64'd42);
    check("mul_latency", lat, 64'd33);
    held = result0;
    in_valid0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_result", {32'd0, result0}, {32'd0, held});
      check("stall_in_ready", {63'd0, in_ready0}, 64'd0);
      check("stall_out_valid", {63'd0, out_valid0}, 64'd1);
    end
    in_valid0 = 1'b0;
    ack();
    check("ack_in_ready", {63'd0, in_ready0}, 64'd1);
    check("ack_out_valid", {63'd0, out_valid0}, 64'd0);

    do_mul(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    check("mulh_m1xm1", {32'd0, res}, 64'h0000_0000);
    check("reaccept_latency", lat, 64'd33);
    ack();
    do_mul(0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    check("mulhu_ffxff", {32'd0, res}, 64'hFFFF_FFFE);
    ack();
    do_mul(0, 2'b01, 32'h8000_0000, 32'h8000_0000, res, lat);
    check("mulh_minxmin", {32'd0, res}, 64'h4000_0000);
    ack();
    do_mul(0, 2'b10, 32'hFFFF_FFFF, 32'h0000_0002, res, lat);
    check("mulhsu_m1x2", {32'd0, res}, 64'hFFFF_FFFF);
    ack();
    do_mul(0, 2'b10, 32'h0000_0002, 32'hFFFF_FFFF, res, lat);
    check("mulhsu_2xff", {32'd0, res}, 64'h0000_0001);
    ack();
    do_mul(0, 2'b00, 32'hFFFF_FFFD, 32'd5, res, lat);
    check("mul_m3x5", {32'd0, res}, 64'hFFFF_FFF1);
    ack();
    do_mul(0, 2'b11, 32'hDEAD_BEEF, 32'h1234_5678, res, lat);
    check("mulhu_r1", {32'd0, res}, 64'h0FD5_BDEE);
    ack();

    // Flush at iteration 10, flush beating a request in IDLE, then a clean 3x5.
    held = result0;
    mul_op = 2'b00;
    data_a = 32'd9;
    data_b = 32'd9;
    in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_in_ready", {63'd0, in_ready0}, 64'd1);
    check("flush_out_valid", {63'd0, out_valid0}, 64'd0);
    flush = 1'b1;
    in_valid0 = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid0 = 1'b0;
    check("flush_blocks_accept", {63'd0, in_ready0}, 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid0) seen++;
    end
    check("flush_no_valid", seen, 64'd0);
    check("flush_result_held", {32'd0, result0}, {32'd0, held});
    do_mul(0, 2'b00, 32'd3, 32'd5, res, lat);
    check("mul_3x5", {32'd0, res}, 64'd15);
    ack();

    // Asynchronous reset in the middle of BUSY.
    mul_op = 2'b00;
    data_a = 32'd11;
    data_b = 32'd13;
    in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", {63'd0, in_ready0}, 64'd1);
    check("arst_out_valid", {63'd0, out_valid0}, 64'd0);
    check("arst_result", {32'd0, result0}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Radix-4 instance.
    do_mul(1, 2'b11, 32'hDEAD_BEEF, 32'h1234_5678, res, lat);
    check("mulhu_r4", {32'd0, res}, 64'h0FD5_BDEE);
    check("r4_latency", lat, 64'd9);
    ack();
    do_mul(1, 2'b01, 32'h8000_0000, 32'h8000_0000, res, lat);
    check("mulh_min_r4", {32'd0, res}, 64'h4000_0000);
    ack();

    // Zero operand: short path only when the bypass is built in.
    do_mul(0, 2'b00, 32'd0, 32'h0000_1234, res, lat);
    check("mul_zero", {32'd0, res}, 64'd0);
`ifdef MULT_ZERO_BYPASS_EN
    check("zero_latency", lat, 64'd1);
`else
    check("zero_latency", lat, 64'd33);
`endif
    ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
